cw_deserializer: RTL and testbench



---
 rtl/cw_deserializer_if.sv | 27 ++
 rtl/cw_deserializer.sv | 97 +++++++++
 tb/tb_cw_deserializer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cw_deserializer_if.sv
// Codeword deserializer bus: serial bitstream in, assembled codeword out
// with a valid/ready handshake, plus framing status.
interface cw_deserializer_if #(
   parameter int N = 46
);
   logic         bit_in;
   logic         bit_valid;
   logic         sof;
   logic [0:N-1] cw_out;
   logic         cw_valid;
   logic         cw_ready;
   logic         busy;
   logic         sync_err;
   logic         ovf;

   // Channel/link side driving bits and consuming codewords
   modport master (
      output bit_in, bit_valid, sof, cw_ready,
      input  cw_out, cw_valid, busy, sync_err, ovf
   );

   // Deserializer side
   modport slave (
      input  bit_in, bit_valid, sof, cw_ready,
      output cw_out, cw_valid, busy, sync_err, ovf
   );
endinterface

// File: rtl/cw_deserializer.sv
// Serial-to-parallel frame assembler feeding the n46k32b6 decoder.
// Frames start on sof; a completed 46-bit word moves into a valid/ready
// output register, or is dropped with an ovf pulse if that register is full.
module cw_deserializer #(
   parameter int N = 46
) (
   input logic               clk,
   input logic               rst_n,
   cw_deserializer_if.slave  bus
);
   localparam int CW = $clog2(N);

   typedef enum logic {HUNT, COLLECT} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [0:N-1]   sr_q, sr_d;
   logic [0:N-1]   cw_out_q, cw_out_d;
   logic           cw_valid_q, cw_valid_d;
   logic           busy_q, busy_d;
   logic           sync_err_q, sync_err_d;
   logic           ovf_q, ovf_d;
   logic           complete;

   // Next-state: collector, frame completion and output-register transfer
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      cw_out_d   = cw_out_q;
      cw_valid_d = cw_valid_q & ~bus.cw_ready;
      sync_err_d = 1'b0;
      ovf_d      = 1'b0;
      complete   = 1'b0;

      if (bus.bit_valid) begin
         if (bus.sof) begin
            // Start (or restart) of frame; a restart discards the partial word
            sync_err_d = (state_q == COLLECT);
            sr_d       = '0;
            sr_d[0]    = bus.bit_in;
            cnt_d      = CW'(1);
            state_d    = COLLECT;
         end else if (state_q == COLLECT) begin
            sr_d[cnt_q] = bus.bit_in;
            if (cnt_q == CW'(N-1)) begin
               complete = 1'b1;
               cnt_d    = '0;
               state_d  = HUNT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      // The transfer uses sr_d so the completing bit is part of the word
      if (complete) begin
         if (!cw_valid_q || bus.cw_ready) begin
            cw_out_d   = sr_d;
            cw_valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      busy_d = (state_d == COLLECT);
   end

   // State and registered outputs; async reset drops everything at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         cnt_q      <= '0;
         sr_q       <= '0;
         cw_out_q   <= '0;
         cw_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         sync_err_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         cw_out_q   <= cw_out_d;
         cw_valid_q <= cw_valid_d;
         busy_q     <= busy_d;
         sync_err_q <= sync_err_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.cw_out   = cw_out_q;
   assign bus.cw_valid = cw_valid_q;
   assign bus.busy     = busy_q;
   assign bus.sync_err = sync_err_q;
   assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_cw_deserializer.sv
// Bench for cw_deserializer: expected words are queued when frames are
// driven and compared when the DUT hands a word over (valid & ready).
module tb_cw_deserializer;
   localparam int N = 46;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [0:N-1] sb_q[$];

   cw_deserializer_if #(.N(N)) bus();

   cw_deserializer #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // One clock; a handshake before the edge consumes the head of the scoreboard
   task automatic tick();
      logic [0:N-1] e;
      if (bus.cw_valid && bus.cw_ready) begin
         chk("sb_has_item", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_word", 64'(bus.cw_out), 64'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic b, input logic s);
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      bus.sof       = s;
      tick();
      bus.bit_valid = 1'b0;
      bus.sof       = 1'b0;
   endtask

   // Idle cycle with random junk on bit_in/sof; bit_valid=0 must hide it
   task automatic idle();
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'($urandom_range(1, 0));
      bus.sof       = 1'($urandom_range(1, 0));
      tick();
      bus.sof       = 1'b0;
   endtask

   task automatic send_word(input logic [0:N-1] w, input bit gaps);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            for (int g = 0; g < 3; g++)
               if ($urandom_range(1, 0) == 1) idle();
         end
         beat(w[i], i == 0);
      end
   endtask

   function automatic logic [0:N-1] alt_word();
      logic [0:N-1] w;
      for (int i = 0; i < N; i++) w[i] = 1'(i & 1);
      return w;
   endfunction

   function automatic logic [0:N-1] rnd_word();
      logic [0:N-1] w;
      for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(1, 0));
      return w;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cw"},    64'(bus.cw_out), 64'd0);
      chk({tag, "_valid"}, 64'(bus.cw_valid), 64'd0);
      chk({tag, "_busy"},  64'(bus.busy), 64'd0);
      chk({tag, "_serr"},  64'(bus.sync_err), 64'd0);
      chk({tag, "_ovf"},   64'(bus.ovf), 64'd0);
   endtask

   initial begin
      logic [0:N-1] wa, wb, wr;
      bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.sof = 1'b0; bus.cw_ready = 1'b1;

      // Reset state
      #12;
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Alternating pattern, ready high
      wa = alt_word();
      sb_q.push_back(wa);
      for (int i = 0; i < N; i++) begin
         beat(wa[i], i == 0);
         if (i == 10) chk("alt_busy_mid", 64'(bus.busy), 64'd1);
         if (i < N - 1 && bus.cw_valid) chk("alt_early_valid", 64'(bus.cw_valid), 64'd0);
      end
      chk("alt_valid", 64'(bus.cw_valid), 64'd1);
      chk("alt_word",  64'(bus.cw_out), 64'(wa));
      chk("alt_b0",    64'(bus.cw_out[0]), 64'd0);
      chk("alt_b45",   64'(bus.cw_out[N-1]), 64'd1);
      chk("alt_busy_end", 64'(bus.busy), 64'd0);
      tick();
      chk("alt_valid_drop", 64'(bus.cw_valid), 64'd0);

      // Back-to-back with ready low: second frame overflows
      bus.cw_ready = 1'b0;
      wa = rnd_word();
      wb = ~wa;
      sb_q.push_back(wa);
      send_word(wa, 1'b0);
      chk("b2b_ovf_first", 64'(bus.ovf), 64'd0);
      send_word(wb, 1'b0);
      chk("b2b_ovf", 64'(bus.ovf), 64'd1);
      chk("b2b_hold", 64'(bus.cw_out), 64'(wa));
      chk("b2b_valid", 64'(bus.cw_valid), 64'd1);
      tick();
      chk("b2b_ovf_pulse", 64'(bus.ovf), 64'd0);
      bus.cw_ready = 1'b1;
      tick();
      bus.cw_ready = 1'b0;
      chk("b2b_valid_drop", 64'(bus.cw_valid), 64'd0);
      bus.cw_ready = 1'b1;

      // Back-to-back with ready high: both frames delivered, no bubble
      wa = rnd_word();
      wb = rnd_word();
      sb_q.push_back(wa);
      sb_q.push_back(wb);
      send_word(wa, 1'b0);
      send_word(wb, 1'b0);
      chk("b2b2_valid", 64'(bus.cw_valid), 64'd1);
      chk("b2b2_ovf", 64'(bus.ovf), 64'd0);
      tick();

      // Resync at beat 20
      wr = rnd_word();
      sb_q.push_back(wr);
      for (int i = 0; i < 20; i++) beat(1'($urandom_range(1, 0)), i == 0);
      chk("rs_serr_before", 64'(bus.sync_err), 64'd0);
      beat(wr[0], 1'b1);
      chk("rs_serr", 64'(bus.sync_err), 64'd1);
      chk("rs_busy", 64'(bus.busy), 64'd1);
      for (int i = 1; i < N; i++) begin
         beat(wr[i], 1'b0);
         if (i == 1) chk("rs_serr_pulse", 64'(bus.sync_err), 64'd0);
         if (i == 1) chk("rs_busy_after", 64'(bus.busy), 64'd1);
      end
      chk("rs_valid", 64'(bus.cw_valid), 64'd1);
      tick();

      // Random gaps on bit_valid
      wa = alt_word();
      sb_q.push_back(wa);
      send_word(wa, 1'b1);
      chk("gap_valid", 64'(bus.cw_valid), 64'd1);
      chk("gap_word", 64'(bus.cw_out), 64'(wa));
      tick();
      chk("gap_valid_drop", 64'(bus.cw_valid), 64'd0);

      // Leading non-sof beats in HUNT are ignored
      for (int i = 0; i < 7; i++) beat(1'b1, 1'b0);
      chk("hunt_busy", 64'(bus.busy), 64'd0);
      chk("hunt_valid", 64'(bus.cw_valid), 64'd0);
      wa = rnd_word();
      sb_q.push_back(wa);
      send_word(wa, 1'b0);
      chk("hunt_valid_after", 64'(bus.cw_valid), 64'd1);
      tick();

      // Async reset mid-frame at beat 30
      wa = rnd_word();
      for (int i = 0; i < 30; i++) beat(wa[i], i == 0);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("arst_mid");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Async reset while cw_valid=1 (word not consumed, not expected)
      bus.cw_ready = 1'b0;
      send_word(rnd_word(), 1'b0);
      chk("arst_pre_valid", 64'(bus.cw_valid), 64'd1);
      #3 rst_n = 1'b0;
      #1 chk_all_zero("arst_valid");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      bus.cw_ready = 1'b1;

      // Frame after reset is assembled correctly
      wa = rnd_word();
      sb_q.push_back(wa);
      send_word(wa, 1'b0);
      chk("post_rst_word", 64'(bus.cw_out), 64'(wa));
      tick();
      tick();

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
